ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 117 +++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between a slotted CPU and a request/ack host port.
// Define RAM_ARBITER_HOLD_EN to build in the host bulk-load hold mode (CPU stalled).
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              dblclk,
  input  logic              reset,
  input  logic              cpu_phase,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_hold_req,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t              r_state;
  logic                r_host_we;
  logic [ADDR_W-1:0]   r_host_addr;
  logic [DATA_W-1:0]   r_host_wdata;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                r_host_ack;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_cpu_slot;
  logic                r_cpu_hold;
  logic                w_hold_req;
  logic                w_host_own;

`ifdef RAM_ARBITER_HOLD_EN
  assign w_hold_req = host_hold_req;
`else
  logic w_unused_hold;
  assign w_unused_hold = host_hold_req;
  assign w_hold_req    = 1'b0;
`endif

  assign w_host_own = (r_state == ISSUE);
  assign ram_addr   = w_host_own ? r_host_addr  : cpu_addr;
  assign ram_wdata  = w_host_own ? r_host_wdata : cpu_wdata;
  assign ram_we     = w_host_own ? r_host_we    : (cpu_we & cpu_phase);

  assign cpu_rdata  = r_cpu_rdata;
  assign host_rdata = r_host_rdata;
  assign host_ack   = r_host_ack;
  assign cpu_hold   = r_cpu_hold;

  always_ff @(posedge dblclk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_host_we    <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= '0;
      r_host_rdata <= '0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_slot   <= 1'b0;
      r_cpu_hold   <= 1'b0;
    end else begin
      r_host_ack <= 1'b0;
      // RAM read data trails the address by one cycle, so CPU capture is deferred.
      r_cpu_slot <= cpu_phase & ~w_host_own;
      if (r_cpu_slot) r_cpu_rdata <= ram_rdata;

      case (r_state)
        IDLE: begin
          if (w_hold_req) begin
            r_state    <= HOLD;
            r_cpu_hold <= 1'b1;
          end else if (host_req && !cpu_phase) begin
            r_state      <= ISSUE;
            r_host_we    <= host_we;
            r_host_addr  <= host_addr;
            r_host_wdata <= host_wdata;
          end
        end
        HOLD: begin
          if (!w_hold_req) begin
            r_state    <= IDLE;
            r_cpu_hold <= 1'b0;
          end else if (host_req) begin
            r_state      <= ISSUE;
            r_host_we    <= host_we;
            r_host_addr  <= host_addr;
            r_host_wdata <= host_wdata;
          end
        end
        ISSUE: r_state <= CAPTURE;
        CAPTURE: begin
          r_host_ack <= 1'b1;
          if (!r_host_we) r_host_rdata <= ram_rdata;
          if (w_hold_req) begin
            r_state    <= HOLD;
            r_cpu_hold <= 1'b1;
          end else begin
            r_state    <= IDLE;
            r_cpu_hold <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: read-first synchronous RAM model plus a host-read-data scoreboard.
module tb_ram_arbiter;

  logic       dblclk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_phase = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [3:0] cpu_wdata = '0;
  logic       cpu_we = 1'b0;
  logic [3:0] cpu_rdata;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [3:0] host_wdata = '0;
  logic       host_ack;
  logic [3:0] host_rdata;
  logic       host_hold_req = 1'b0;
  logic       cpu_hold;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       ram_we;
  logic [3:0] ram_rdata;

  ram_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
    .dblclk(dblclk), .reset(reset),
    .cpu_phase(cpu_phase), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_hold_req(host_hold_req), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 dblclk = ~dblclk;

  // RAM model with a bench-side preload port.
  logic [3:0] mem [256];
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [3:0] ld_dat = '0;
  always @(posedge dblclk) begin
    ram_rdata <= mem[ram_addr];
    if (ld_we)       mem[ld_addr]  <= ld_dat;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit tgl = 1'b0;
  logic [3:0] exp_mem [256];
  logic [3:0] exp_hrd = '0;
  logic [3:0] exp_q [$];

  always @(posedge dblclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge dblclk) begin
    if (reset && host_ack) begin
      if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
      else check("host_rdata", host_rdata, exp_q.pop_front());
    end
  end

  task automatic host_start(input logic we, input logic [7:0] a, input logic [3:0] d, input bit push);
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    if (push) begin
      if (we) exp_mem[a] = d;
      else    exp_hrd = exp_mem[a];
      exp_q.push_back(exp_hrd);
    end
  endtask

  task automatic wait_ack(output int lat, output int at);
    lat = 0; at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge dblclk);
      if (tgl) cpu_phase = ~cpu_phase;
      if (host_ack) begin
        lat = i; at = cyc;
        break;
      end
    end
    host_req = 1'b0;
    if (lat == 0) check("ack_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, at, prev_at;
    #3;
    check("rst_host_ack", host_ack, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    ld_we = 1'b1; ld_addr = 8'h2A; ld_dat = 4'h7; exp_mem[8'h2A] = 4'h7;
    @(negedge dblclk);
    ld_addr = 8'h10; ld_dat = 4'h9; exp_mem[8'h10] = 4'h9;
    @(negedge dblclk);
    ld_we = 1'b0;
    reset = 1'b1;
    @(negedge dblclk);

    // Host read from an idle bus.
    host_start(1'b0, 8'h2A, 4'h0, 1'b1);
    wait_ack(lat, at);
    check("rd_latency", lat, 3);
    @(negedge dblclk);
    check("ack_pulse", host_ack, 0);

    // CPU write slot wins; host waits.
    cpu_phase = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 4'h5;
    exp_mem[8'h10] = 4'h5;
    host_start(1'b0, 8'h10, 4'h0, 1'b1);
    #1;
    check("cpu_ram_we", ram_we, 1);
    check("cpu_ram_addr", ram_addr, 8'h10);
    check("cpu_ram_wdata", ram_wdata, 4'h5);
    @(negedge dblclk);
    check("no_ack_cpu_slot", host_ack, 0);
    cpu_phase = 1'b0; cpu_we = 1'b0;
    wait_ack(lat, at);
    check("wait_latency", lat, 3);
    check("cpu_rdata_slot", cpu_rdata, 4'h9);

    // Back-to-back write then read of 0xFF.
    host_start(1'b1, 8'hFF, 4'hC, 1'b1);
    wait_ack(lat, at);
    check("wr_latency", lat, 3);
    check("cpu_rdata_hold1", cpu_rdata, 4'h9);
    prev_at = at;
    host_start(1'b0, 8'hFF, 4'h0, 1'b1);
    wait_ack(lat, at);
    check("b2b_spacing", at - prev_at, 3);
    check("cpu_rdata_hold2", cpu_rdata, 4'h9);

    // Reset during ISSUE aborts the access.
    cpu_addr = 8'h00; cpu_wdata = 4'h0;
    @(negedge dblclk);
    host_start(1'b0, 8'h2A, 4'h0, 1'b0);
    @(negedge dblclk);
    check("issue_ram_addr", ram_addr, 8'h2A);
    reset = 1'b0;
    host_req = 1'b0;
    #1;
    check("abort_host_ack", host_ack, 0);
    check("abort_host_rdata", host_rdata, 0);
    check("abort_cpu_rdata", cpu_rdata, 0);
    check("abort_cpu_hold", cpu_hold, 0);
    check("abort_ram_we", ram_we, 0);
    check("abort_ram_addr", ram_addr, 0);
    exp_hrd = 4'h0;
    @(negedge dblclk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge dblclk);
      check("abort_no_ack", host_ack, 0);
    end
    host_start(1'b0, 8'h2A, 4'h0, 1'b1);
    wait_ack(lat, at);
    check("post_rst_latency", lat, 3);

`ifdef RAM_ARBITER_HOLD_EN
    @(negedge dblclk);
    host_hold_req = 1'b1;
    @(negedge dblclk);
    check("hold_on", cpu_hold, 1);
    tgl = 1'b1;
    prev_at = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      logic [3:0] d;
      a = 8'h40 + 8'(i);
      d = 4'h1 + 4'(i);
      host_start(1'b1, a, d, 1'b1);
      wait_ack(lat, at);
      check("hold_ack_cpu_hold", cpu_hold, 1);
      if (i == 0) check("hold_latency", lat, 3);
      else        check("hold_spacing", at - prev_at, 3);
      prev_at = at;
    end
    host_hold_req = 1'b0;
    tgl = 1'b0;
    cpu_phase = 1'b0;
    @(negedge dblclk);
    check("hold_off", cpu_hold, 0);
    host_start(1'b0, 8'h42, 4'h0, 1'b1);
    wait_ack(lat, at);
    check("hold_readback_lat", lat, 3);
`else
    @(negedge dblclk);
    host_hold_req = 1'b1;
    cpu_phase = 1'b1;
    host_start(1'b0, 8'h2A, 4'h0, 1'b1);
    @(negedge dblclk);
    check("nohold_cpu_hold", cpu_hold, 0);
    check("nohold_no_ack1", host_ack, 0);
    @(negedge dblclk);
    check("nohold_no_ack2", host_ack, 0);
    cpu_phase = 1'b0;
    wait_ack(lat, at);
    check("nohold_latency", lat, 3);
    check("nohold_cpu_hold2", cpu_hold, 0);
    host_hold_req = 1'b0;
`endif

    @(negedge dblclk);
    @(negedge dblclk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
